// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl_pkg
// Purpose : Shared types for the RV32I pipeline hazard controller: FSM state
//           encoding, EX operand forward-select encoding, and the scoreboard
//           entry layout with its source-match helper.
// Revision: 1.0  initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  // RV32I register file address width.
  localparam int RV_REG_ADR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // EX operand source select.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result held in MEM
  localparam logic [1:0] FWD_WB  = 2'b10;  // write-back data

  typedef struct packed {
    logic                    valid;
    logic [RV_REG_ADR_W-1:0] rd;
    logic                    we;
    logic                    is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: '0, we: 1'b0, is_load: 1'b0};

  // An in-flight producer matches a DEC source when it will write a non-zero
  // register that the DEC instruction actually reads.
  function automatic logic sb_match(
    input sb_entry_t               e,
    input logic [RV_REG_ADR_W-1:0] rs,
    input logic                    rs_used,
    input logic                    dec_valid
  );
    return e.valid && e.we && (e.rd != '0) && (e.rd == rs) && rs_used && dec_valid;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Purpose : Three-entry (EX/MEM/WB) destination scoreboard with per-source
//           match comparators against the instruction currently in DEC.
// Ports   : clk, rst          clock, asynchronous active-high reset
//           advance_i         pipeline moves this edge (no freeze)
//           flush_i           redirect: discard all tracked producers
//           dec_entry_i       entry to load into EX (valid=0 for a bubble)
//           dec_valid_i       DEC holds a valid instruction
//           rs1_i/rs2_i       DEC source addresses
//           rs1_used_i/rs2_used_i  source read enables
//           hit_a_o/hit_b_o   match per entry, bit0=EX bit1=MEM bit2=WB
//           load_use_o        EX entry is a load matching either source
// Revision: 1.0  initial release
// ============================================================================
module hazard_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance_i,
  input  logic                    flush_i,
  input  sb_entry_t               dec_entry_i,
  input  logic                    dec_valid_i,
  input  logic [RV_REG_ADR_W-1:0] rs1_i,
  input  logic [RV_REG_ADR_W-1:0] rs2_i,
  input  logic                    rs1_used_i,
  input  logic                    rs2_used_i,
  output logic [2:0]              hit_a_o,
  output logic [2:0]              hit_b_o,
  output logic                    load_use_o
);

  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t wb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= SB_EMPTY;
      mem_q <= SB_EMPTY;
      wb_q  <= SB_EMPTY;
    end else if (advance_i) begin
      if (flush_i) begin
        // The instruction in MEM is killed, so it never reaches WB either.
        ex_q  <= SB_EMPTY;
        mem_q <= SB_EMPTY;
        wb_q  <= SB_EMPTY;
      end else begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= dec_entry_i;
      end
    end
  end

  assign hit_a_o = {sb_match(wb_q,  rs1_i, rs1_used_i, dec_valid_i),
                    sb_match(mem_q, rs1_i, rs1_used_i, dec_valid_i),
                    sb_match(ex_q,  rs1_i, rs1_used_i, dec_valid_i)};

  assign hit_b_o = {sb_match(wb_q,  rs2_i, rs2_used_i, dec_valid_i),
                    sb_match(mem_q, rs2_i, rs2_used_i, dec_valid_i),
                    sb_match(ex_q,  rs2_i, rs2_used_i, dec_valid_i)};

  assign load_use_o = ex_q.is_load & (hit_a_o[0] | hit_b_o[0]);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Purpose : Hazard/sequencing controller for a 5-stage RV32I pipeline.
//           Generates IF/DEC stalls, EX bubbles, redirect flush, memory-wait
//           freeze, registered EX forward selects and a saturating stall
//           cycle counter.
// Config  : FORWARDING_EN - when defined, stall only on load-use or WB-entry
//           match and forward from MEM/WB; otherwise stall on any match and
//           tie forward selects to the register file.
// Ports   : clk, rst                 clock, asynchronous active-high reset
//           dec_*                    DEC-stage instruction description
//           wb_pc_src                taken redirect resolved in WB
//           mem_ready                data memory done (0 = wait)
//           stall_if/stall_dec       hold PC/IF and DEC registers
//           bubble_ex                load NOP into EX
//           freeze                   hold every pipeline register
//           flush                    kill DEC/EX/MEM
//           fwd_a_sel/fwd_b_sel      EX operand sources (registered)
//           stall_cycles             saturating count of stall_dec cycles
// Revision: 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADR_W   = RV_REG_ADR_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid,
  input  logic [REG_ADR_W-1:0]   dec_rs1,
  input  logic [REG_ADR_W-1:0]   dec_rs2,
  input  logic                   dec_rs1_used,
  input  logic                   dec_rs2_used,
  input  logic [REG_ADR_W-1:0]   dec_rd,
  input  logic                   dec_rf_we,
  input  logic                   dec_is_load,
  input  logic                   wb_pc_src,
  input  logic                   mem_ready,
  output logic                   stall_if,
  output logic                   stall_dec,
  output logic                   bubble_ex,
  output logic                   freeze,
  output logic                   flush,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  state_e                 state_q, state_d;
  logic                   redirect_pend_q, redirect_pend_d;
  logic [1:0]             fwd_a_q, fwd_b_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic       w_freeze;
  logic       w_flush;
  logic       w_hz_en;
  logic       w_hazard;
  logic       w_stall;
  logic       w_load_ex;
  logic [2:0] w_hit_a;
  logic [2:0] w_hit_b;
  logic       w_load_use;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  sb_entry_t  w_dec_entry;

  // --------------------------------------------------------------------------
  // Sequencing: freeze beats flush beats data stall. Everything is gated by
  // rst so the control outputs read 0 for the whole reset interval.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    redirect_pend_d = redirect_pend_q;
    w_freeze        = 1'b0;
    w_flush         = 1'b0;
    w_hz_en         = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (!mem_ready) begin
            w_freeze        = 1'b1;
            redirect_pend_d = wb_pc_src;
            state_d         = ST_MEM_WAIT;
          end else if (wb_pc_src) begin
            w_flush = 1'b1;
            state_d = ST_REDIRECT;
          end else begin
            w_hz_en = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_ready) begin
            w_freeze        = 1'b1;
            redirect_pend_d = redirect_pend_q | wb_pc_src;
          end else begin
            redirect_pend_d = 1'b0;
            if (redirect_pend_q | wb_pc_src) begin
              w_flush = 1'b1;
              state_d = ST_REDIRECT;
            end else begin
              // The pipeline advances on release, so the DEC instruction
              // must still be checked before it is allowed into EX.
              w_hz_en = 1'b1;
              state_d = ST_RUN;
            end
          end
        end
        ST_REDIRECT: begin
          // DEC holds the killed slot: no hazard check, EX gets a bubble.
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Hazard decision and forward selection
  // --------------------------------------------------------------------------
`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded; WB is stalled on because the
  // register file does not write through to a same-cycle read.
  assign w_hazard = w_load_use | w_hit_a[2] | w_hit_b[2];
  // Youngest producer wins.
  assign w_fwd_a  = w_hit_a[0] ? FWD_MEM : (w_hit_a[1] ? FWD_WB : FWD_RF);
  assign w_fwd_b  = w_hit_b[0] ? FWD_MEM : (w_hit_b[1] ? FWD_WB : FWD_RF);
`else
  // Without bypass paths any in-flight producer blocks the read; load-use is
  // a subset of that and is folded in so both builds consume the same terms.
  assign w_hazard = (|w_hit_a) | (|w_hit_b) | w_load_use;
  assign w_fwd_a  = FWD_RF;
  assign w_fwd_b  = FWD_RF;
`endif

  assign w_stall     = w_hz_en & w_hazard;
  assign w_load_ex   = w_hz_en & dec_valid & ~w_stall;
  assign w_dec_entry = '{valid: w_load_ex, rd: dec_rd, we: dec_rf_we, is_load: dec_is_load};

  hazard_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .advance_i   (~w_freeze),
    .flush_i     (w_flush),
    .dec_entry_i (w_dec_entry),
    .dec_valid_i (dec_valid),
    .rs1_i       (dec_rs1),
    .rs2_i       (dec_rs2),
    .rs1_used_i  (dec_rs1_used),
    .rs2_used_i  (dec_rs2_used),
    .hit_a_o     (w_hit_a),
    .hit_b_o     (w_hit_b),
    .load_use_o  (w_load_use)
  );

  // --------------------------------------------------------------------------
  // State, forward-select and counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_RUN;
      redirect_pend_q <= 1'b0;
      fwd_a_q         <= FWD_RF;
      fwd_b_q         <= FWD_RF;
      stall_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      redirect_pend_q <= redirect_pend_d;
      // Selects follow the instruction into EX; a bubble gets the RF select.
      if (!w_freeze) begin
        fwd_a_q <= w_load_ex ? w_fwd_a : FWD_RF;
        fwd_b_q <= w_load_ex ? w_fwd_b : FWD_RF;
      end
      if (w_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_if     = w_stall;
  assign stall_dec    = w_stall;
  assign bubble_ex    = w_stall;
  assign freeze       = w_freeze;
  assign flush        = w_flush;
  assign fwd_a_sel    = fwd_a_q;
  assign fwd_b_sel    = fwd_b_q;
  assign stall_cycles = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Purpose : Directed self-checking bench for pipeline_hazard_ctrl. Expected
//           values are hand-derived; the FORWARDING_EN build selects the
//           forwarding scenarios, the default build the full-stall scenario.
// Revision: 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_rs1_used;
  logic        dec_rs2_used;
  logic [4:0]  dec_rd;
  logic        dec_rf_we;
  logic        dec_is_load;
  logic        wb_pc_src;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_dec;
  logic        bubble_ex;
  logic        freeze;
  logic        flush;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [15:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_hazard_ctrl #(.REG_ADR_W(5), .STALL_CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rs1_used (dec_rs1_used),
    .dec_rs2_used (dec_rs2_used),
    .dec_rd       (dec_rd),
    .dec_rf_we    (dec_rf_we),
    .dec_is_load  (dec_is_load),
    .wb_pc_src    (wb_pc_src),
    .mem_ready    (mem_ready),
    .stall_if     (stall_if),
    .stall_dec    (stall_dec),
    .bubble_ex    (bubble_ex),
    .freeze       (freeze),
    .flush        (flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld);
    dec_valid    = v;
    dec_rs1      = rs1;
    dec_rs2      = rs2;
    dec_rs1_used = u1;
    dec_rs2_used = u2;
    dec_rd       = rd;
    dec_rf_we    = we;
    dec_is_load  = ld;
  endtask

  task automatic idle3();
    set_dec(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick(); tick(); tick();
  endtask

  initial begin
    rst       = 1'b1;
    wb_pc_src = 1'b0;
    mem_ready = 1'b1;
    set_dec(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick(); tick();

    // ---- reset state ----
    chk("rst_stall_dec", stall_dec, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_flush", flush, 0);
    chk("rst_fwd_a", fwd_a_sel, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    mem_ready = 1'b0;
    #1 chk("rst_freeze_gated", freeze, 0);
    mem_ready = 1'b1;
    rst = 1'b0;
    tick();

    // ---- x0 producer then x0 reader: never stalls ----
    set_dec(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    #1 chk("x0_prod_stall", stall_dec, 0);
    tick();
    set_dec(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    #1 chk("x0_cons_stall", stall_dec, 0);
    tick();
    chk("x0_fwd_a", fwd_a_sel, 2'b00);
    chk("x0_fwd_b", fwd_b_sel, 2'b00);
    idle3();

`ifdef FORWARDING_EN
    // ---- ALU producer -> consumer: forward from MEM, no stall ----
    set_dec(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_dec(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1 chk("fwd_alu_stall", stall_dec, 0);
    tick();
    chk("fwd_alu_a", fwd_a_sel, 2'b01);
    chk("fwd_alu_b", fwd_b_sel, 2'b00);
    idle3();

    // ---- load-use: one stall + bubble, then forward from WB ----
    set_dec(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1 chk("lu_stall_dec", stall_dec, 1);
    chk("lu_stall_if", stall_if, 1);
    chk("lu_bubble", bubble_ex, 1);
    tick();
    #1 chk("lu_stall_done", stall_dec, 0);
    tick();
    chk("lu_fwd_a", fwd_a_sel, 2'b10);
    chk("lu_fwd_b", fwd_b_sel, 2'b10);
    chk("lu_stall_cycles", stall_cycles, 1);
    idle3();
`else
    // ---- no forwarding: dependent add stalls through EX, MEM, WB ----
    set_dec(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    #1 chk("nf_prod_stall", stall_dec, 0);
    tick();
    set_dec(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1 chk("nf_stall_ex", stall_dec, 1);
    chk("nf_stall_if", stall_if, 1);
    chk("nf_bubble", bubble_ex, 1);
    tick();
    #1 chk("nf_stall_mem", stall_dec, 1);
    tick();
    #1 chk("nf_stall_wb", stall_dec, 1);
    tick();
    #1 chk("nf_stall_done", stall_dec, 0);
    chk("nf_stall_cycles", stall_cycles, 3);
    tick();
    chk("nf_fwd_a", fwd_a_sel, 2'b00);
    idle3();
`endif

    // ---- memory wait 4 cycles with redirect pulsed in cycle 2 ----
    mem_ready = 1'b0;
    #1 chk("mw_c1_freeze", freeze, 1);
    chk("mw_c1_flush", flush, 0);
    tick();
    wb_pc_src = 1'b1;
    #1 chk("mw_c2_freeze", freeze, 1);
    chk("mw_c2_flush", flush, 0);
    tick();
    wb_pc_src = 1'b0;
    #1 chk("mw_c3_freeze", freeze, 1);
    tick();
    #1 chk("mw_c4_freeze", freeze, 1);
    tick();
    mem_ready = 1'b1;
    #1 chk("mw_rel_freeze", freeze, 0);
    chk("mw_rel_flush", flush, 1);
    tick();
    #1 chk("mw_redir_flush", flush, 0);
    chk("mw_redir_freeze", freeze, 0);
    chk("mw_redir_stall", stall_dec, 0);
    tick();

    // ---- asynchronous reset in the middle of a load-use stall ----
    set_dec(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1 chk("ar_stall_before", stall_dec, 1);
    #1 rst = 1'b1;
    #1 chk("ar_stall_dec", stall_dec, 0);
    chk("ar_bubble", bubble_ex, 0);
    chk("ar_stall_cycles", stall_cycles, 0);
    chk("ar_fwd_a", fwd_a_sel, 2'b00);
    chk("ar_flush", flush, 0);
    #1 rst = 1'b0;
    #1 chk("ar_post_stall", stall_dec, 0);
    wb_pc_src = 1'b1;
    #1 chk("ar_run_flush", flush, 1);
    tick();
    wb_pc_src = 1'b0;
    set_dec(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 chk("ar_redir_flush", flush, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
